// File: rtl/sam_mouse_pkg.sv
// Shared constants and helpers for the SAM Coupé mouse interface.
package sam_mouse_pkg;
  localparam int FRAME_LEN = 11;
  localparam int SYNC_BIT  = 3;
  localparam int ACC_W     = 12;

  localparam logic [3:0] IDX_STROBE = 4'd0;
  localparam logic [3:0] IDX_BTN    = 4'd1;
  localparam logic [3:0] IDX_Y      = 4'd2;
  localparam logic [3:0] IDX_X      = 4'd5;
  localparam logic [3:0] IDX_END    = 4'd8;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [8:0] d);
    return {{(ACC_W-9){d[8]}}, d};
  endfunction

  // One extra bit of headroom; the top two bits of the sum tell overflow direction.
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [8:0] d);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W-8){d[8]}}, d};
    case (s[ACC_W:ACC_W-1])
      2'b01:   return {1'b0, {(ACC_W-1){1'b1}}};
      2'b10:   return {1'b1, {(ACC_W-1){1'b0}}};
      default: return s[ACC_W-1:0];
    endcase
  endfunction
endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: 2-flop sync, clock glitch filter, 11-bit frame shifter, watchdog.
module ps2_rx
  import sam_mouse_pkg::*;
#(
  parameter int FILT_LEN = 8
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data
);
  localparam int FW = $clog2(FILT_LEN + 1);

  logic [1:0]    clk_s, dat_s;
  logic          clk_f;
  logic [FW-1:0] fcnt;
  logic [3:0]    bitcnt;
  logic [8:0]    shreg;
  logic [11:0]   wd;

  wire edge_acc = (clk_f != clk_s[1]) && (fcnt == FW'(FILT_LEN - 1));
  wire fall     = edge_acc && clk_f;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_s      <= 2'b11;
      dat_s      <= 2'b11;
      clk_f      <= 1'b1;
      fcnt       <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      wd         <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      clk_s      <= {clk_s[0], ps2_clk};
      dat_s      <= {dat_s[0], ps2_data};
      byte_valid <= 1'b0;

      if (clk_f == clk_s[1]) fcnt <= '0;
      else if (edge_acc) begin
        clk_f <= clk_s[1];
        fcnt  <= '0;
      end else fcnt <= fcnt + 1'b1;

      if (bitcnt == 4'd0 || edge_acc) wd <= '0;
      else                            wd <= wd + 1'b1;

      if (fall) begin
        if (bitcnt == 4'd0) begin
          if (!dat_s[1]) bitcnt <= 4'd1;
        end else if (bitcnt == 4'(FRAME_LEN - 1)) begin
          // shreg holds 8 data bits plus parity; odd parity means odd XOR
          byte_valid <= dat_s[1] && (^shreg);
          byte_data  <= shreg[7:0];
          bitcnt     <= 4'd0;
        end else begin
          shreg  <= {dat_s[1], shreg[8:1]};
          bitcnt <= bitcnt + 4'd1;
        end
      end else if (wd == 12'hFFF) begin
        bitcnt <= 4'd0;
      end
    end
  end
endmodule

// File: rtl/sam_mouse.sv
// SAM Coupé mouse: PS/2 packets integrated into X/Y deltas, served as a nibble sequence.
module sam_mouse
  import sam_mouse_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4800,
  parameter int FILT_LEN    = 8
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_mouse_clk,
  input  logic       ps2_mouse_data,
  input  logic       rd_strobe,
  output logic [3:0] dout,
  output logic       present
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic       byte_valid;
  logic [7:0] byte_data;

  ps2_rx #(.FILT_LEN(FILT_LEN)) u_rx (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_mouse_clk),
    .ps2_data  (ps2_mouse_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data)
  );

  logic [1:0]              bidx;
  logic [2:0]              b0_btn, btn;
  logic                    b0_sx, b0_sy;
  logic [7:0]              b1;
  logic signed [ACC_W-1:0] acc_x, acc_y, lat_x, lat_y;
  logic [3:0]              idx;
  logic [TW-1:0]           tcnt;
  logic                    ovf_unused;

  assign ovf_unused = ^byte_data[7:6];

  wire              pkt_done  = byte_valid && (bidx == 2'd2);
  wire              seq_start = rd_strobe && (idx == IDX_STROBE);
  wire signed [8:0] dx        = {b0_sx, b1};
  wire signed [8:0] dy        = {b0_sy, byte_data};

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bidx    <= 2'd0;
      b0_btn  <= '0;
      b0_sx   <= 1'b0;
      b0_sy   <= 1'b0;
      b1      <= '0;
      btn     <= '0;
      present <= 1'b0;
    end else if (byte_valid) begin
      case (bidx)
        2'd0: if (byte_data[SYNC_BIT]) begin
          b0_btn <= byte_data[2:0];
          b0_sx  <= byte_data[4];
          b0_sy  <= byte_data[5];
          bidx   <= 2'd1;
        end
        2'd1: begin
          b1   <= byte_data;
          bidx <= 2'd2;
        end
        default: begin
          btn     <= b0_btn;
          present <= 1'b1;
          bidx    <= 2'd0;
        end
      endcase
    end
  end

  // A packet landing on the latching read seeds the fresh accumulators.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      acc_x <= '0;
      acc_y <= '0;
      lat_x <= '0;
      lat_y <= '0;
    end else if (seq_start) begin
      lat_x <= acc_x;
      lat_y <= acc_y;
      acc_x <= pkt_done ? sext(dx) : '0;
      acc_y <= pkt_done ? sext(dy) : '0;
    end else if (pkt_done) begin
      acc_x <= sat_add(acc_x, dx);
      acc_y <= sat_add(acc_y, dy);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      idx  <= IDX_STROBE;
      tcnt <= '0;
    end else if (rd_strobe) begin
      tcnt <= '0;
      if (idx != IDX_END) idx <= idx + 4'd1;
    end else if (tcnt == TW'(TIMEOUT_CYC)) begin
      idx <= IDX_STROBE;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_comb begin
    dout = 4'hF;
    case (idx)
      IDX_BTN:                dout = {1'b1, ~btn[2], ~btn[1], ~btn[0]};
      IDX_Y:                  dout = lat_y[11:8];
      4'(IDX_Y + 4'd1):       dout = lat_y[7:4];
      4'(IDX_Y + 4'd2):       dout = lat_y[3:0];
      IDX_X:                  dout = lat_x[11:8];
      4'(IDX_X + 4'd1):       dout = lat_x[7:4];
      4'(IDX_X + 4'd2):       dout = lat_x[3:0];
      default:                dout = 4'hF;
    endcase
  end
endmodule

// File: tb/tb_sam_mouse.sv
// Directed bench for sam_mouse: PS/2 packet driver, nibble readout, hand-computed expectations.
module tb_sam_mouse;
  localparam int TO   = 300;
  localparam int FL   = 8;
  localparam int HALF = 10;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_mouse_clk = 1'b1;
  logic       ps2_mouse_data = 1'b1;
  logic       rd_strobe = 1'b0;
  logic [3:0] dout;
  logic       present;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [3:0] seq [0:8];
  logic [3:0] expn [0:8];
  event       stop_ev;

  always #5 clk_sys = ~clk_sys;

  sam_mouse #(.TIMEOUT_CYC(TO), .FILT_LEN(FL)) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ps2_mouse_clk (ps2_mouse_clk),
    .ps2_mouse_data(ps2_mouse_data),
    .rd_strobe     (rd_strobe),
    .dout          (dout),
    .present       (present)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_sys);
      ps2_mouse_data = fr[i];
      idle(HALF);
      ps2_mouse_clk = 1'b0;
      if (i == 10) -> stop_ev;
      idle(HALF);
      ps2_mouse_clk = 1'b1;
    end
    idle(30);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic rd(output logic [3:0] n);
    @(negedge clk_sys);
    n = dout;
    rd_strobe = 1'b1;
    @(negedge clk_sys);
    rd_strobe = 1'b0;
  endtask

  task automatic read_seq(input int n);
    logic [3:0] t;
    for (int i = 0; i < n; i++) begin
      rd(t);
      seq[i] = t;
    end
  endtask

  task automatic chk_seq(input string tag);
    for (int i = 0; i < 9; i++) chk($sformatf("%s_nib%0d", tag, i), seq[i], expn[i]);
  endtask

  function automatic int nib3(input int b);
    return int'({seq[b], seq[b+1], seq[b+2]});
  endfunction

  initial begin
    int x1, x2, n_old, n_new;
    n_old = 0;
    n_new = 0;
    idle(3);
    reset = 1'b0;

    // reset defaults
    chk("rst_present", present, 0);
    chk("rst_dout", dout, 4'hF);
    read_seq(9);
    expn = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
    chk_seq("rst");

    // dx=+5, dy=-3 (Y sign from b0[5])
    send_pkt(8'h28, 8'h05, 8'hFD);
    chk("pkt_present", present, 1);
    idle(TO + 2);
    read_seq(9);
    expn = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hD, 4'h0, 4'h0, 4'h5, 4'hF};
    chk_seq("pkt");

    // left button
    send_pkt(8'h09, 8'h00, 8'h00);
    idle(TO + 2);
    read_seq(9);
    chk("btn_l", seq[1], 4'hE);
    chk("btn_x", nib3(5), 0);

    // positive saturation
    for (int i = 0; i < 20; i++) send_pkt(8'h08, 8'h7F, 8'h00);
    idle(TO + 2);
    read_seq(9);
    chk("sat_x", nib3(5), 12'h7FF);
    chk("sat_y", nib3(2), 0);

    // timeout restart, L+M pressed -> button nibble A
    send_pkt(8'h0D, 8'h00, 8'h00);
    idle(TO + 2);
    read_seq(3);
    chk("to_pre0", seq[0], 4'hF);
    chk("to_pre1", seq[1], 4'hA);
    chk("to_pre2", seq[2], 4'h0);
    idle(TO + 2);
    read_seq(2);
    chk("to_post0", seq[0], 4'hF);
    chk("to_post1", seq[1], 4'hA);

    // bad parity frame and unsynced first byte are dropped
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b0);
    send_pkt(8'h08, 8'h02, 8'h00);
    idle(TO + 2);
    read_seq(9);
    chk("drop_x", nib3(5), 2);
    chk("drop_y", nib3(2), 0);

    // latching read swept across packet completion: motion conserved
    for (int k = 2; k < 18; k++) begin
      idle(TO + 2);
      read_seq(9);
      send_pkt(8'h08, 8'h03, 8'h00);
      send_byte(8'h08, 1'b0);
      send_byte(8'h10, 1'b0);
      fork
        send_byte(8'h00, 1'b0);
        begin
          @(stop_ev);
          repeat (k) @(negedge clk_sys);
          rd_strobe = 1'b1;
          @(negedge clk_sys);
          rd_strobe = 1'b0;
        end
      join
      read_seq(8);
      x1 = nib3(4);
      idle(TO + 2);
      read_seq(9);
      x2 = nib3(5);
      chk($sformatf("simul_sum_k%0d", k), x1 + x2, 19);
      chk($sformatf("simul_split_k%0d", k), int'(x1 == 3 || x1 == 19), 1);
      if (x1 == 3) n_old++;
      else if (x1 == 19) n_new++;
    end
    chk("simul_old_seen", int'(n_old > 0), 1);
    chk("simul_new_seen", int'(n_new > 0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
